alu_operand_sequencer: RTL and testbench

//  Front-end controller that drives the ALU's a/b/Operator inputs from board switches and buttons,
//  and captures the ALU's Result and N/Z/C/V flags into registers.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_operand_sequencer_if.sv | 32 +++
 rtl/button_debouncer.sv | 43 ++++
 rtl/alu_operand_sequencer.sv | 87 ++++++++
 tb/tb_alu_operand_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, sequencer states and flag positions for the ALU front-end.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_MAX = 4'b1001;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } seq_state_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Board-side and ALU-side signals of the operand sequencer, bundled as one bus.
interface alu_operand_sequencer_if #(parameter int N = 4);

    logic [N-1:0]   sw;
    logic [3:0]     op_sw;
    logic           btn_next;
    logic           btn_clear;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [3:0]     alu_op;
    logic [2*N-1:0] alu_result;
    logic [3:0]     alu_flags;
    logic [2*N-1:0] result_q;
    logic [3:0]     flags_q;
    logic           result_valid;
    logic           div_by_zero;
    logic           op_error;
    logic [2:0]     state_o;

    modport master (
        input  sw, op_sw, btn_next, btn_clear, alu_result, alu_flags,
        output alu_a, alu_b, alu_op, result_q, flags_q, result_valid,
               div_by_zero, op_error, state_o
    );

    modport slave (
        output sw, op_sw, btn_next, btn_clear, alu_result, alu_flags,
        input  alu_a, alu_b, alu_op, result_q, flags_q, result_valid,
               div_by_zero, op_error, state_o
    );

endinterface

// File: rtl/button_debouncer.sv
// Synchronizes a raw bouncing button, debounces it and emits one pulse per accepted press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [1:0]       sync;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Level flips only after an unbroken run of disagreeing samples; pulse lags the rise by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '0;
            level     <= 1'b0;
            level_d   <= 1'b0;
            cnt       <= '0;
            btn_pulse <= 1'b0;
        end else begin
            sync      <= {sync[0], btn_raw};
            level_d   <= level;
            btn_pulse <= level & ~level_d;
            if (sync[1] != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps operand A, operand B and opcode into a combinational ALU, then latches its result and flags.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic                   clk,
    input logic                   rst,
    alu_operand_sequencer_if.master bus
);

    seq_state_t state;
    logic       next_p;
    logic       clear_p;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (bus.btn_next),
        .btn_pulse (next_p)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (bus.btn_clear),
        .btn_pulse (clear_p)
    );

    assign bus.state_o = state;

    // Clear behaves exactly like reset and wins over a coincident next press.
    always_ff @(posedge clk) begin
        if (rst || clear_p) begin
            state            <= LOAD_A;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.alu_op       <= '0;
            bus.result_q     <= '0;
            bus.flags_q      <= '0;
            bus.result_valid <= 1'b0;
            bus.div_by_zero  <= 1'b0;
            bus.op_error     <= 1'b0;
        end else begin
            case (state)
                LOAD_A: if (next_p) begin
                    bus.alu_a <= bus.sw;
                    state     <= LOAD_B;
                end
                LOAD_B: if (next_p) begin
                    bus.alu_b <= bus.sw;
                    state     <= LOAD_OP;
                end
                LOAD_OP: if (next_p) begin
                    bus.alu_op      <= bus.op_sw;
                    bus.div_by_zero <= is_div_op(bus.op_sw) && (bus.alu_b == '0);
                    bus.op_error    <= bus.op_sw > OP_MAX;
                    state           <= EXEC;
                end
                // One settle cycle with stable ALU inputs before capturing.
                EXEC: begin
                    if (bus.op_error) begin
                        bus.result_q <= '0;
                        bus.flags_q  <= '0;
                    end else if (bus.div_by_zero) begin
                        bus.result_q <= {(2*N){1'b1}};
                        bus.flags_q  <= '0;
                    end else begin
                        bus.result_q <= bus.alu_result;
                        bus.flags_q  <= bus.alu_flags;
                    end
                    bus.result_valid <= 1'b1;
                    state            <= SHOW;
                end
                SHOW: if (next_p) begin
                    bus.result_valid <= 1'b0;
                    bus.div_by_zero  <= 1'b0;
                    bus.op_error     <= 1'b0;
                    state            <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: bounce rejection, table of ALU operations, clear priority and reset during EXEC.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_operand_sequencer_if #(.N(N)) bus ();

    alu_operand_sequencer #(.N(N), .DEBOUNCE_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Small reference ALU standing in for the team ALU (n=4).
    logic [4:0] alu_s;
    always_comb begin
        alu_s          = '0;
        bus.alu_result = '0;
        bus.alu_flags  = '0;
        case (bus.alu_op)
            OP_ADD: begin
                alu_s                 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_result        = {3'b000, alu_s};
                bus.alu_flags[FLAG_C] = alu_s[4];
                bus.alu_flags[FLAG_V] = (bus.alu_a[3] == bus.alu_b[3]) && (alu_s[3] != bus.alu_a[3]);
            end
            OP_SUB: begin
                alu_s                 = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                bus.alu_result        = {4'b0000, alu_s[3:0]};
                bus.alu_flags[FLAG_C] = alu_s[4];
                bus.alu_flags[FLAG_V] = (bus.alu_a[3] != bus.alu_b[3]) && (alu_s[3] != bus.alu_a[3]);
            end
            OP_MUL: bus.alu_result = {4'b0000, bus.alu_a} * {4'b0000, bus.alu_b};
            OP_DIV: bus.alu_result = (bus.alu_b != 0) ? {4'b0000, bus.alu_a / bus.alu_b} : 8'h00;
            OP_MOD: bus.alu_result = (bus.alu_b != 0) ? {4'b0000, bus.alu_a % bus.alu_b} : 8'h00;
            OP_AND: bus.alu_result = {4'b0000, bus.alu_a & bus.alu_b};
            OP_OR:  bus.alu_result = {4'b0000, bus.alu_a | bus.alu_b};
            OP_XOR: bus.alu_result = {4'b0000, bus.alu_a ^ bus.alu_b};
            OP_SHL: bus.alu_result = {4'b0000, bus.alu_a} << bus.alu_b;
            OP_SHR: bus.alu_result = {4'b0000, bus.alu_a >> bus.alu_b};
            default: bus.alu_result = 8'h00;
        endcase
        if (bus.alu_op == OP_ADD || bus.alu_op == OP_SUB) begin
            bus.alu_flags[FLAG_N] = alu_s[3];
            bus.alu_flags[FLAG_Z] = (alu_s[3:0] == 4'h0);
        end else begin
            bus.alu_flags[FLAG_N] = bus.alu_result[7];
            bus.alu_flags[FLAG_Z] = (bus.alu_result == 8'h00);
        end
    end

    int passed = 0;
    int total  = 0;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [7:0] result;
        logic [3:0] flags;
        logic       dbz;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic nxt, input logic clr, input int hold);
        @(negedge clk);
        bus.btn_next  = nxt;
        bus.btn_clear = clr;
        idle(hold);
        bus.btn_next  = 1'b0;
        bus.btn_clear = 1'b0;
        idle(10);
    endtask

    task automatic wait_state(input seq_state_t target, input string name);
        int cycles = 0;
        while (bus.state_o != target && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        check_output(name, 32'(bus.state_o), 32'(target));
    endtask

    initial begin
        vecs[0] = '{"add",     4'd3,  4'd5, OP_ADD,  8'h08, 4'b1001, 1'b0, 1'b0};
        vecs[1] = '{"mul",     4'd7,  4'd6, OP_MUL,  8'h2A, 4'b0000, 1'b0, 1'b0};
        vecs[2] = '{"div0",    4'd9,  4'd0, OP_DIV,  8'hFF, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{"op1100",  4'd2,  4'd3, 4'b1100, 8'h00, 4'b0000, 1'b0, 1'b1};
        vecs[4] = '{"sub",     4'd3,  4'd5, OP_SUB,  8'h0E, 4'b1010, 1'b0, 1'b0};
        vecs[5] = '{"xor",     4'd9,  4'd9, OP_XOR,  8'h00, 4'b0100, 1'b0, 1'b0};
        vecs[6] = '{"mod0",    4'd7,  4'd0, OP_MOD,  8'hFF, 4'b0000, 1'b1, 1'b0};
        vecs[7] = '{"op1010",  4'd4,  4'd0, 4'b1010, 8'h00, 4'b0000, 1'b0, 1'b1};
        vecs[8] = '{"shr",     4'd8,  4'd3, OP_SHR,  8'h01, 4'b0000, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.sw        = '0;
        bus.op_sw     = '0;
        bus.btn_next  = 1'b0;
        bus.btn_clear = 1'b0;
        idle(3);
        check_output("rst_state", 32'(bus.state_o), 32'(LOAD_A));
        check_output("rst_result", 32'(bus.result_q), 32'h0);
        check_output("rst_valid", 32'(bus.result_valid), 32'h0);
        check_output("rst_alu_a", 32'(bus.alu_a), 32'h0);
        rst = 1'b0;
        idle(2);

        // Bouncing button: only the final steady hold may register, and only once.
        bus.sw = 4'hA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.btn_next = ~bus.btn_next;
        end
        idle(2);
        check_output("bounce_no_press", 32'(bus.state_o), 32'(LOAD_A));
        apply_stimulus(1'b1, 1'b0, 20);
        check_output("bounce_state", 32'(bus.state_o), 32'(LOAD_B));
        check_output("bounce_alu_a", 32'(bus.alu_a), 32'hA);

        // Clear and next together in LOAD_B.
        apply_stimulus(1'b1, 1'b1, 10);
        check_output("clr_state", 32'(bus.state_o), 32'(LOAD_A));
        check_output("clr_alu_a", 32'(bus.alu_a), 32'h0);

        for (int i = 0; i < 9; i++) begin
            bus.sw = vecs[i].a;
            apply_stimulus(1'b1, 1'b0, 10);
            check_output({vecs[i].name, "_st_b"}, 32'(bus.state_o), 32'(LOAD_B));
            check_output({vecs[i].name, "_alu_a"}, 32'(bus.alu_a), 32'(vecs[i].a));
            bus.sw = vecs[i].b;
            apply_stimulus(1'b1, 1'b0, 10);
            check_output({vecs[i].name, "_st_op"}, 32'(bus.state_o), 32'(LOAD_OP));
            check_output({vecs[i].name, "_alu_b"}, 32'(bus.alu_b), 32'(vecs[i].b));
            bus.op_sw = vecs[i].op;
            @(negedge clk);
            bus.btn_next = 1'b1;
            wait_state(EXEC, {vecs[i].name, "_exec"});
            check_output({vecs[i].name, "_valid_exec"}, 32'(bus.result_valid), 32'h0);
            @(negedge clk);
            check_output({vecs[i].name, "_st_show"}, 32'(bus.state_o), 32'(SHOW));
            check_output({vecs[i].name, "_valid"}, 32'(bus.result_valid), 32'h1);
            check_output({vecs[i].name, "_result"}, 32'(bus.result_q), 32'(vecs[i].result));
            check_output({vecs[i].name, "_flags"}, 32'(bus.flags_q), 32'(vecs[i].flags));
            check_output({vecs[i].name, "_dbz"}, 32'(bus.div_by_zero), 32'(vecs[i].dbz));
            check_output({vecs[i].name, "_err"}, 32'(bus.op_error), 32'(vecs[i].err));
            check_output({vecs[i].name, "_alu_op"}, 32'(bus.alu_op), 32'(vecs[i].op));
            idle(4);
            bus.btn_next = 1'b0;
            idle(10);
            check_output({vecs[i].name, "_hold_show"}, 32'(bus.state_o), 32'(SHOW));
            apply_stimulus(1'b1, 1'b0, 10);
            check_output({vecs[i].name, "_st_a"}, 32'(bus.state_o), 32'(LOAD_A));
            check_output({vecs[i].name, "_valid_off"}, 32'(bus.result_valid), 32'h0);
            check_output({vecs[i].name, "_dbz_off"}, 32'(bus.div_by_zero), 32'h0);
            check_output({vecs[i].name, "_err_off"}, 32'(bus.op_error), 32'h0);
            check_output({vecs[i].name, "_a_kept"}, 32'(bus.alu_a), 32'(vecs[i].a));
        end

        // Reset in the middle of EXEC.
        bus.sw = 4'd5;
        apply_stimulus(1'b1, 1'b0, 10);
        bus.sw = 4'd2;
        apply_stimulus(1'b1, 1'b0, 10);
        bus.op_sw = OP_ADD;
        @(negedge clk);
        bus.btn_next = 1'b1;
        wait_state(EXEC, "rstx_exec");
        rst          = 1'b1;
        bus.btn_next = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_output("rstx_state", 32'(bus.state_o), 32'(LOAD_A));
        check_output("rstx_alu_a", 32'(bus.alu_a), 32'h0);
        check_output("rstx_alu_b", 32'(bus.alu_b), 32'h0);
        check_output("rstx_result", 32'(bus.result_q), 32'h0);
        check_output("rstx_flags", 32'(bus.flags_q), 32'h0);
        check_output("rstx_valid", 32'(bus.result_valid), 32'h0);
        idle(3);
        check_output("rstx_stay", 32'(bus.state_o), 32'(LOAD_A));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
